// File: rtl/mem_pkg.sv
// Shared definitions for the dual-core memory port arbiter.
//   ADDR_W    : word address width (byte address bits [15:1])
//   DATA_W    : memory data width
//   core_id_e : requester encoding, CORE1=0, CORE2=1
//   rd_tag_t  : read-in-flight tag {valid, core id}
package mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic {
    CORE1 = 1'b0,
    CORE2 = 1'b1
  } core_id_e;

  typedef struct packed {
    logic     vld;
    core_id_e core;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-bit pointer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (pointer returns to requester 0)
//   req   : request vector, bit0 = requester 0, bit1 = requester 1
//   grant : one-hot grant, combinational from req and pointer
// The pointer selects the winner only when both request, and flips only on
// those contested cycles so the loser is favoured next time.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;
  logic contested;

  assign contested = req[0] & req[1];

  always_comb begin
    grant = req;
    if (contested) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (contested) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two cores onto a memory with one read port and one write port.
// Read and write ports are arbitrated independently, each by its own rr_arb2.
// Optional feature: define ARB_PERF_CNT_EN to build the saturating conflict
// counter; otherwise conflict_cnt is tied to 0.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   pause[1:0]                 : bit0 pauses core1, bit1 pauses core2
//   req_valid/wen/addr/wdata_k : core k request (wen=1 write, 0 read)
//   stall_k                    : core k request not accepted this cycle
//   rdata_valid_k, rdata_k     : read return, one cycle after the grant
//   mem_ren/raddr, mem_rdata   : memory read port (data one cycle after ren)
//   mem_wen/waddr/wdata        : memory write port
//   conflict_cnt               : cycles with a contested port (saturating)
module mem_port_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pause,
  input  logic              req_valid_1,
  input  logic              req_wen_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  input  logic              req_valid_2,
  input  logic              req_wen_2,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [DATA_W-1:0] req_wdata_2,
  output logic              stall_1,
  output logic              rdata_valid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              stall_2,
  output logic              rdata_valid_2,
  output logic [DATA_W-1:0] rdata_2,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [15:0]       conflict_cnt
);

  logic       act_1, act_2;
  logic [1:0] rd_req, wr_req;
  logic [1:0] rd_grant, wr_grant;
  rd_tag_t    tag_p1;

  // Gating with rst_n keeps both ports idle while reset is held.
  assign act_1  = rst_n & req_valid_1 & ~pause[0];
  assign act_2  = rst_n & req_valid_2 & ~pause[1];
  assign rd_req = {act_2 & ~req_wen_2, act_1 & ~req_wen_1};
  assign wr_req = {act_2 &  req_wen_2, act_1 &  req_wen_1};

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .grant (rd_grant)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .grant (wr_grant)
  );

  // Stage p0: grants drive the memory ports in the request cycle.
  always_comb begin
    mem_ren   = |rd_grant;
    mem_raddr = '0;
    if (rd_grant[0]) begin
      mem_raddr = req_addr_1;
    end else if (rd_grant[1]) begin
      mem_raddr = req_addr_2;
    end

    mem_wen   = |wr_grant;
    mem_waddr = '0;
    mem_wdata = '0;
    if (wr_grant[0]) begin
      mem_waddr = req_addr_1;
      mem_wdata = req_wdata_1;
    end else if (wr_grant[1]) begin
      mem_waddr = req_addr_2;
      mem_wdata = req_wdata_2;
    end
  end

  assign stall_1 = ~rst_n | pause[0] | (act_1 & ~(rd_grant[0] | wr_grant[0]));
  assign stall_2 = ~rst_n | pause[1] | (act_2 & ~(rd_grant[1] | wr_grant[1]));

  // Stage p1: read tag follows the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_p1 <= '{vld: 1'b0, core: CORE1};
    end else begin
      tag_p1.vld  <= mem_ren;
      tag_p1.core <= rd_grant[1] ? CORE2 : CORE1;
    end
  end

  // rst_n gating drops a read whose data would land during reset.
  assign rdata_valid_1 = rst_n & tag_p1.vld & (tag_p1.core == CORE1);
  assign rdata_valid_2 = rst_n & tag_p1.vld & (tag_p1.core == CORE2);
  assign rdata_1       = rdata_valid_1 ? mem_rdata : '0;
  assign rdata_2       = rdata_valid_2 ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic        contested;
  logic [15:0] cnt;

  assign contested = (&rd_req) | (&wr_req);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (contested && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign conflict_cnt = cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a
// read-return scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pause;
  logic        req_valid_1, req_wen_1, req_valid_2, req_wen_2;
  logic [14:0] req_addr_1, req_addr_2;
  logic [15:0] req_wdata_1, req_wdata_2;
  logic        stall_1, stall_2, rdata_valid_1, rdata_valid_2;
  logic [15:0] rdata_1, rdata_2;
  logic        mem_ren, mem_wen;
  logic [14:0] mem_raddr, mem_waddr;
  logic [15:0] mem_rdata, mem_wdata, conflict_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic        core;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mem [0:32767];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pause         (pause),
    .req_valid_1   (req_valid_1),
    .req_wen_1     (req_wen_1),
    .req_addr_1    (req_addr_1),
    .req_wdata_1   (req_wdata_1),
    .req_valid_2   (req_valid_2),
    .req_wen_2     (req_wen_2),
    .req_addr_2    (req_addr_2),
    .req_wdata_2   (req_wdata_2),
    .stall_1       (stall_1),
    .rdata_valid_1 (rdata_valid_1),
    .rdata_1       (rdata_1),
    .stall_2       (stall_2),
    .rdata_valid_2 (rdata_valid_2),
    .rdata_2       (rdata_2),
    .mem_ren       (mem_ren),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .mem_wen       (mem_wen),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .conflict_cnt  (conflict_cnt)
  );

  function automatic logic [15:0] pat(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5C3;
  endfunction

  // Memory: registered read of pre-write contents, write on the same edge.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_conf();
`ifdef ARB_PERF_CNT_EN
    return (exp_cnt > 65535) ? 16'hFFFF : exp_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // Read-return monitor: every rdata_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rdata_valid_1 || rdata_valid_2) begin
      chk("rdata_onehot", {31'd0, rdata_valid_1 & rdata_valid_2}, 32'd0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rdata_unexpected: observed v1=%0b v2=%0b expected none",
               rdata_valid_1, rdata_valid_2);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata_core", {31'd0, rdata_valid_2}, {31'd0, e.core});
        chk("rdata_value", {16'd0, rdata_valid_2 ? rdata_2 : rdata_1}, {16'd0, e.data});
      end
    end
  end

  task automatic cyc(input logic r, input logic [1:0] p,
                     input logic v1, input logic w1, input logic [14:0] a1, input logic [15:0] d1,
                     input logic v2, input logic w2, input logic [14:0] a2, input logic [15:0] d2);
    @(posedge clk);
    #1;
    rst_n = r; pause = p;
    req_valid_1 = v1; req_wen_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
    req_valid_2 = v2; req_wen_2 = w2; req_addr_2 = a2; req_wdata_2 = d2;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 15'd0, 16'd0, 1'b0, 1'b0, 15'd0, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = pat(i[14:0]);
    mem_rdata = '0;
    rst_n = 1'b0; pause = 2'b00;
    req_valid_1 = 1'b0; req_wen_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0;
    req_valid_2 = 1'b0; req_wen_2 = 1'b0; req_addr_2 = '0; req_wdata_2 = '0;

    // Reset held with requests present: everything idle, both stalled.
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 15'h0001, 16'd0, 1'b1, 1'b1, 15'h0002, 16'h1234);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 15'h0001, 16'd0, 1'b1, 1'b1, 15'h0002, 16'h1234);
    chk("rst_stall_1", {31'd0, stall_1}, 32'd1);
    chk("rst_stall_2", {31'd0, stall_2}, 32'd1);
    chk("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_rvalid", {30'd0, rdata_valid_2, rdata_valid_1}, 32'd0);
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);

    // Idle after release: no stall, memory buses zeroed.
    idle();
    chk("idle_stall", {30'd0, stall_2, stall_1}, 32'd0);
    chk("idle_raddr", {17'd0, mem_raddr}, 32'd0);
    chk("idle_waddr_wdata", {1'b0, mem_waddr, mem_wdata}, 32'd0);

    // Contested read: core1 first, then core2 alone.
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 15'h0010, 16'd0, 1'b1, 1'b0, 15'h0200, 16'd0);
    exp_cnt++;
    chk("rd1_raddr", {17'd0, mem_raddr}, 32'h0010);
    chk("rd1_stalls", {30'd0, stall_2, stall_1}, 32'b10);
    chk("rd1_ren", {31'd0, mem_ren}, 32'd1);
    sb.push_back('{1'b0, pat(15'h0010)});
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0, 1'b1, 1'b0, 15'h0200, 16'd0);
    chk("rd2_raddr", {17'd0, mem_raddr}, 32'h0200);
    chk("rd2_stall_2", {31'd0, stall_2}, 32'd0);
    chk("rd2_rvalid", {30'd0, rdata_valid_2, rdata_valid_1}, 32'b01);
    sb.push_back('{1'b1, pat(15'h0200)});
    idle();
    chk("rd3_rvalid", {30'd0, rdata_valid_2, rdata_valid_1}, 32'b10);

    // Both cores writing for four cycles: grants alternate starting at core1.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'b00, 1'b1, 1'b1, 15'h0020, 16'h1111, 1'b1, 1'b1, 15'h0021, 16'h2222);
      exp_cnt++;
      chk("wr_alt_waddr", {17'd0, mem_waddr}, (i % 2 == 0) ? 32'h0020 : 32'h0021);
      chk("wr_alt_wdata", {16'd0, mem_wdata}, (i % 2 == 0) ? 32'h1111 : 32'h2222);
      chk("wr_alt_stalls", {30'd0, stall_2, stall_1}, (i % 2 == 0) ? 32'b10 : 32'b01);
    end
    idle();
    chk("wr_alt_cnt", {16'd0, conflict_cnt}, {16'd0, exp_conf()});

    // Same-cycle read and write of one address: read returns old data.
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 15'h0005, 16'd0, 1'b1, 1'b1, 15'h0005, 16'hBEEF);
    chk("rw_stalls", {30'd0, stall_2, stall_1}, 32'd0);
    chk("rw_en", {30'd0, mem_wen, mem_ren}, 32'b11);
    chk("rw_addrs", {2'd0, mem_raddr, mem_waddr}, {2'd0, 15'h0005, 15'h0005});
    chk("rw_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    sb.push_back('{1'b0, pat(15'h0005)});
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 15'h0005, 16'd0, 1'b0, 1'b0, 15'h0000, 16'd0);
    sb.push_back('{1'b0, 16'hBEEF});
    idle();

    // Core2 paused while both read: core1 wins every cycle, no core2 address.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'b10, 1'b1, 1'b0, 15'h0030, 16'd0, 1'b1, 1'b0, 15'h0040, 16'd0);
      chk("pause_raddr", {17'd0, mem_raddr}, 32'h0030);
      chk("pause_stalls", {30'd0, stall_2, stall_1}, 32'b10);
      sb.push_back('{1'b0, pat(15'h0030)});
    end
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 15'h0000, 16'd0, 1'b0, 1'b0, 15'h0000, 16'd0);
    chk("pause_idle_stall_2", {31'd0, stall_2}, 32'd1);
    idle();
    chk("pre_rst_cnt", {16'd0, conflict_cnt}, {16'd0, exp_conf()});

    // Read pointer now favours core2; reset right after its grant.
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 15'h0100, 16'd0, 1'b1, 1'b0, 15'h0200, 16'd0);
    chk("ptr_raddr", {17'd0, mem_raddr}, 32'h0200);
    chk("ptr_stalls", {30'd0, stall_2, stall_1}, 32'b01);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0, 1'b0, 1'b0, 15'h0000, 16'd0);
    exp_cnt = 0;
    chk("rstfly_rvalid", {30'd0, rdata_valid_2, rdata_valid_1}, 32'd0);
    chk("rstfly_stalls", {30'd0, stall_2, stall_1}, 32'b11);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0, 1'b0, 1'b0, 15'h0000, 16'd0);
    idle();
    chk("post_rst_rvalid", {30'd0, rdata_valid_2, rdata_valid_1}, 32'd0);
    cyc(1'b1, 2'b00, 1'b1, 1'b0, 15'h0100, 16'd0, 1'b1, 1'b0, 15'h0200, 16'd0);
    exp_cnt++;
    chk("post_rst_raddr", {17'd0, mem_raddr}, 32'h0100);
    chk("post_rst_stalls", {30'd0, stall_2, stall_1}, 32'b10);
    sb.push_back('{1'b0, pat(15'h0100)});
    idle();
    idle();
    chk("post_rst_cnt", {16'd0, conflict_cnt}, {16'd0, exp_conf()});

`ifdef ARB_PERF_CNT_EN
    // Saturation: 70000 contested write cycles.
    cyc(1'b1, 2'b00, 1'b1, 1'b1, 15'h0050, 16'h0A0A, 1'b1, 1'b1, 15'h0051, 16'h0B0B);
    for (int i = 0; i < 69999; i++) @(posedge clk);
    exp_cnt += 70000;
    idle();
    chk("sat_cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
    cyc(1'b1, 2'b00, 1'b1, 1'b1, 15'h0050, 16'h0A0A, 1'b1, 1'b1, 15'h0051, 16'h0B0B);
    idle();
    chk("sat_hold_cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
`endif

    idle();
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: pause  input  2  bit0=core1 paused, bit1=core2 paused.
REQ-004 SHALL have ports, per core k in {1,2}: req_valid_k  input  1; req_wen_k  input  1 (1=write, 0=read); req_addr_k  input  15 (word address [15:1]); req_wdata_k  input  16.
REQ-005 SHALL have ports, per core k: stall_k  output  1  request not accepted this cycle; rdata_valid_k  output  1; rdata_k  output  16.
REQ-006 SHALL have memory-side ports: mem_ren  output  1; mem_raddr  output  15; mem_rdata  input  16 (valid one cycle after mem_ren); mem_wen  output  1; mem_waddr  output  15; mem_wdata  output  16.
REQ-007 SHALL have port conflict_cnt  output  16  count of cycles with a lost arbitration.

Function
REQ-008 SHALL arbitrate the read port and the write port independently; core1 read plus core2 write (or the reverse) are both granted in the same cycle.
REQ-009 SHALL treat a request from core k as absent while pause[k-1]=1, and SHALL drive stall_k=1 during that time.
REQ-010 SHALL, when both cores request the same port, grant the core selected by that port's round-robin pointer (rr_rd or rr_wr; 0 selects core1) and SHALL drive stall=1 to the loser in the same cycle, combinationally.
REQ-011 SHALL toggle a port's pointer to favour the other core only on cycles where that port is contested; an uncontested grant leaves it unchanged.
REQ-012 SHALL, on a read grant, drive mem_ren=1 and mem_raddr=granted address, and register a tag {valid, core id}.
REQ-013 SHALL, one cycle after a read grant, assert rdata_valid_k for exactly one cycle on the tagged core, with rdata_k=mem_rdata; the other core's rdata_valid SHALL be 0.
REQ-014 SHALL, on a write grant, drive mem_wen=1, mem_waddr and mem_wdata from the winner in the same cycle.
REQ-015 SHALL leave same-cycle read and write to one address to the memory: the read returns pre-write data.
REQ-016 SHALL drive mem_raddr, mem_waddr and mem_wdata to 0 when the corresponding enable is 0.
REQ-017 SHALL require a stalled core to hold its request stable; a request withdrawn while stalled is dropped without error.
REQ-018 SHALL keep stall_k=0 for a core with no request and not paused.

Reset
REQ-019 SHALL, while rst_n=0 at a clock edge: clear rr_rd and rr_wr to 0, clear the read tag, and clear conflict_cnt.
REQ-020 SHALL hold mem_ren=0, mem_wen=0, rdata_valid_1/2=0 and stall_1/2=1 while rst_n=0.
REQ-021 SHALL drop a read in flight when reset is asserted; no rdata_valid follows reset release.

Configuration
REQ-022 SHALL, with ARB_PERF_CNT_EN defined, increment conflict_cnt by 1 per cycle in which either port is contested, saturating at 16'hFFFF.
REQ-023 SHALL, without ARB_PERF_CNT_EN, tie conflict_cnt to 0 and synthesise no counter.

Structure
REQ-024 SHALL put the core-id encoding (CORE1=0, CORE2=1), the address width 15 and the data width 16 in the shared package mem_pkg.
REQ-025 SHALL implement one sub-module rr_arb2: a two-requester round-robin arbiter with a one-bit pointer, instantiated once per port.

Verification
REQ-026 Both cores read, addr 15'h0010 / 15'h0200, after reset -> core1 granted, stall_2=1; next cycle rdata_valid_1=1 and core2 granted; the cycle after, rdata_valid_2=1.
REQ-027 Both cores write continuously for 4 cycles -> grants alternate core1, core2, core1, core2; with ARB_PERF_CNT_EN, conflict_cnt=4.
REQ-028 Core1 reads 15'h0005 while core2 writes 16'hBEEF to 15'h0005 -> both granted, no stall; core1 receives old data; a later read returns 16'hBEEF.
REQ-029 pause=2'b10 with both cores reading -> core1 granted every cycle, stall_2=1, mem never sees core2's address.
REQ-030 Assert rst_n=0 in the cycle after a read grant -> rdata_valid_k stays 0; after release the first contested read goes to core1.
REQ-031 With conflict_cnt preloaded near saturation by 70000 contested cycles -> value stays at 16'hFFFF.
